// File: rtl/somador_pkg.sv
// Shared types for the somador pipelined add/sub/accumulate unit.
// Operation encoding and default counter width.
package somador_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ACC  = 2'd2,
    OP_LOAD = 2'd3
  } op_e;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/somador_pipe_if.sv
// Operand/result handshake bundle for somador_pipe.
// master drives operands and out_ready; slave is the unit.
interface somador_pipe_if
  import somador_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  op_e              op;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     s;
  logic             flag;
  logic [CNT_W-1:0] ovf_cnt;

  modport master (
    output in_valid,
    output a,
    output b,
    output op,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  s,
    input  flag,
    input  ovf_cnt
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  op,
    input  out_ready,
    output in_ready,
    output out_valid,
    output s,
    output flag,
    output ovf_cnt
  );

endinterface

// File: rtl/somador_sat.sv
// Signed add/sub at W+1 bits with overflow detect and optional clamp.
// Purely combinational; direction of clamp follows the true sign bit.
module somador_sat #(
  parameter int W   = 8,
  parameter int SAT = 0
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] r,
  output logic         ovf
);

  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

  logic [W:0] xe;
  logic [W:0] ye;
  logic [W:0] ext;
  logic       sx;
  logic       sy;
  logic       sr;

  assign xe  = {x[W-1], x};
  assign ye  = {y[W-1], y};
  assign ext = sub ? (xe - ye) : (xe + ye);

  assign sx = x[W-1];
  assign sy = y[W-1];
  assign sr = ext[W-1];

  always_comb begin
    ovf = 1'b0;
    if (sub) begin
      ovf = (sx != sy) && (sr != sx);
    end else begin
      ovf = (sx == sy) && (sr != sx);
    end
  end

  // ext[W] is the sign of the exact result, even when W bits overflow
  always_comb begin
    r = ext[W-1:0];
    if ((SAT != 0) && ovf) begin
      r = ext[W] ? MINN : MAXP;
    end
  end

endmodule

// File: rtl/somador_pipe.sv
// Two-register pipelined signed add/sub/accumulate with overflow
// flag, optional saturation and a saturating overflow counter.
module somador_pipe
  import somador_pkg::*;
#(
  parameter int W     = 8,
  parameter int SAT   = 0,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic            clk,
  input logic            rst,
  somador_pipe_if.slave  bus
);

  logic             s1_valid;
  logic [W-1:0]     s1_a;
  logic [W-1:0]     s1_b;
  op_e              s1_op;

  logic             out_valid_q;
  logic [W-1:0]     s_q;
  logic             flag_q;
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] cnt_q;

  logic             s2_adv;
  logic             in_ready;

  logic [W-1:0]     x;
  logic [W-1:0]     y;
  logic             sub;
  logic [W-1:0]     r;
  logic             ovf;
  logic [W-1:0]     res;
  logic             res_ovf;
  logic             acc_wr;

  assign s2_adv   = !out_valid_q || bus.out_ready;
  assign in_ready = !s1_valid || s2_adv;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.flag      = flag_q;
  assign bus.ovf_cnt   = cnt_q;

  always_comb begin
    x      = s1_a;
    y      = s1_b;
    sub    = 1'b0;
    acc_wr = 1'b0;
    unique case (s1_op)
      OP_ADD: begin
      end
      OP_SUB: begin
        sub = 1'b1;
      end
      OP_ACC: begin
        x      = acc;
        y      = s1_a;
        acc_wr = 1'b1;
      end
      OP_LOAD: begin
        acc_wr = 1'b1;
      end
    endcase
  end

  somador_sat #(
    .W   (W),
    .SAT (SAT)
  ) u_sat (
    .x   (x),
    .y   (y),
    .sub (sub),
    .r   (r),
    .ovf (ovf)
  );

  // LOAD bypasses the adder and can never overflow
  always_comb begin
    res     = r;
    res_ovf = ovf;
    if (s1_op == OP_LOAD) begin
      res     = s1_a;
      res_ovf = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a  <= bus.a;
        s1_b  <= bus.b;
        s1_op <= bus.op;
      end
    end
  end

  // acc is touched only here, so back-to-back ACC sees the prior result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      flag_q      <= 1'b1;
      acc         <= '0;
      cnt_q       <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        s_q    <= res;
        flag_q <= !res_ovf;
        if (acc_wr) begin
          acc <= res;
        end
        if (res_ovf && (cnt_q != '1)) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_somador_pipe.sv
// Directed bench for somador_pipe: wrap and clamp instances,
// stall/backpressure ordering and async reset with beats in flight.
module tb_somador_pipe;
  import somador_pkg::*;

  localparam int W  = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst0;
  logic         rst1;
  int           sel;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  op_e          op;

  int checks   = 0;
  int failures = 0;

  somador_pipe_if #(.W(W), .CNT_W(CW)) if0 ();
  somador_pipe_if #(.W(W), .CNT_W(CW)) if1 ();

  assign if0.in_valid  = in_valid && (sel == 0);
  assign if0.a         = a;
  assign if0.b         = b;
  assign if0.op        = op;
  assign if0.out_ready = (sel == 0) ? out_ready : 1'b1;

  assign if1.in_valid  = in_valid && (sel == 1);
  assign if1.a         = a;
  assign if1.b         = b;
  assign if1.op        = op;
  assign if1.out_ready = (sel == 1) ? out_ready : 1'b1;

  somador_pipe #(.W(W), .SAT(0), .CNT_W(CW)) dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (if0)
  );

  somador_pipe #(.W(W), .SAT(1), .CNT_W(CW)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1)
  );

  logic          o_valid;
  logic          o_in_ready;
  logic          o_flag;
  logic [W-1:0]  o_s;
  logic [CW-1:0] o_cnt;

  assign o_valid    = (sel == 1) ? if1.out_valid : if0.out_valid;
  assign o_in_ready = (sel == 1) ? if1.in_ready  : if0.in_ready;
  assign o_flag     = (sel == 1) ? if1.flag      : if0.flag;
  assign o_s        = (sel == 1) ? if1.s         : if0.s;
  assign o_cnt      = (sel == 1) ? if1.ovf_cnt   : if0.ovf_cnt;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // one beat through an otherwise idle pipe; lat=-1 if nothing came out
  task automatic xact(input op_e o, input logic [W-1:0] xa,
                      input logic [W-1:0] xb,
                      output logic [W-1:0] rs, output logic rf,
                      output int lat);
    op        = o;
    a         = xa;
    b         = xb;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    lat       = -1;
    rs        = '0;
    rf        = 1'bx;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_in_ready) break;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (o_valid) begin
        lat = i;
        rs  = o_s;
        rf  = o_flag;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sel       = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = OP_ADD;
    rst0      = 1'b1;
    rst1      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    checks++;
    if (if0.out_valid !== 1'b0 || if1.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid got=%b%b exp=00", if0.out_valid, if1.out_valid);
    end
    checks++;
    if (if0.flag !== 1'b1 || if1.flag !== 1'b1) begin
      failures++;
      $display("FAIL rst_flag got=%b%b exp=11", if0.flag, if1.flag);
    end
    checks++;
    if (if0.s !== 8'h00 || if1.s !== 8'h00) begin
      failures++;
      $display("FAIL rst_s got=%h/%h exp=00", if0.s, if1.s);
    end
    checks++;
    if (if0.ovf_cnt !== 16'd0 || if1.ovf_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_cnt got=%0d/%0d exp=0", if0.ovf_cnt, if1.ovf_cnt);
    end
    checks++;
    if (if0.in_ready !== 1'b1 || if1.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_ready got=%b%b exp=11", if0.in_ready, if1.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_wrap();
    logic [W-1:0] rs;
    logic         rf;
    int           lat;
    sel = 0;
    xact(OP_ADD, 8'd100, 8'd50, rs, rf, lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL add_latency got=%0d exp=2", lat);
    end
    checks++;
    if (rs !== 8'h96 || rf !== 1'b0) begin
      failures++;
      $display("FAIL add_wrap_ovf got=%h/%b exp=96/0", rs, rf);
    end
    checks++;
    if (o_cnt !== 16'd1) begin
      failures++;
      $display("FAIL add_wrap_cnt got=%0d exp=1", o_cnt);
    end
    xact(OP_ADD, 8'd20, 8'hE2, rs, rf, lat);
    checks++;
    if (rs !== 8'hF6 || rf !== 1'b1) begin
      failures++;
      $display("FAIL add_exact got=%h/%b exp=f6/1", rs, rf);
    end
  endtask

  task automatic test_add_sat();
    logic [W-1:0] rs;
    logic         rf;
    int           lat;
    sel = 1;
    xact(OP_ADD, 8'd100, 8'd50, rs, rf, lat);
    checks++;
    if (rs !== 8'h7F || rf !== 1'b0) begin
      failures++;
      $display("FAIL sat_pos got=%h/%b exp=7f/0", rs, rf);
    end
    xact(OP_ADD, 8'h9C, 8'hCE, rs, rf, lat);
    checks++;
    if (rs !== 8'h80 || rf !== 1'b0) begin
      failures++;
      $display("FAIL sat_neg got=%h/%b exp=80/0", rs, rf);
    end
    checks++;
    if (o_cnt !== 16'd2) begin
      failures++;
      $display("FAIL sat_cnt got=%0d exp=2", o_cnt);
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] rs;
    logic         rf;
    int           lat;
    sel = 0;
    xact(OP_SUB, 8'h80, 8'h01, rs, rf, lat);
    checks++;
    if (rs !== 8'h7F || rf !== 1'b0) begin
      failures++;
      $display("FAIL sub_min got=%h/%b exp=7f/0", rs, rf);
    end
    xact(OP_SUB, 8'd5, 8'd3, rs, rf, lat);
    checks++;
    if (rs !== 8'h02 || rf !== 1'b1) begin
      failures++;
      $display("FAIL sub_exact got=%h/%b exp=02/1", rs, rf);
    end
    xact(OP_SUB, 8'h00, 8'h80, rs, rf, lat);
    checks++;
    if (rs !== 8'h80 || rf !== 1'b0) begin
      failures++;
      $display("FAIL sub_negmin got=%h/%b exp=80/0", rs, rf);
    end
    checks++;
    if (o_cnt !== 16'd3) begin
      failures++;
      $display("FAIL sub_cnt got=%0d exp=3", o_cnt);
    end
  endtask

  task automatic test_back_to_back();
    op_e          ops [4] = '{OP_LOAD, OP_ACC, OP_ACC, OP_ACC};
    logic [W-1:0] va  [4] = '{8'd10, 8'd20, 8'd30, 8'd100};
    logic [W-1:0] es  [4] = '{8'd10, 8'd30, 8'd60, 8'd127};
    logic         ef  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] rs;
    logic         rf;
    int           lat;
    int           k   = 0;
    int           got = 0;
    logic         acc_now;
    sel       = 1;
    out_ready = 1'b1;
    b         = '0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (k < 4);
      if (k < 4) begin
        op = ops[k];
        a  = va[k];
      end
      @(negedge clk);
      acc_now = in_valid && o_in_ready;
      if (o_valid) begin
        if (got < 4) begin
          checks++;
          if (o_s !== es[got] || o_flag !== ef[got]) begin
            failures++;
            $display("FAIL b2b_beat%0d got=%h/%b exp=%h/%b",
                     got, o_s, o_flag, es[got], ef[got]);
          end
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (acc_now) k++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 4) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=4", got);
    end
    xact(OP_ACC, 8'd0, 8'd0, rs, rf, lat);
    checks++;
    if (rs !== 8'd127 || rf !== 1'b1) begin
      failures++;
      $display("FAIL b2b_acc_held got=%h/%b exp=7f/1", rs, rf);
    end
    checks++;
    if (o_cnt !== 16'd3) begin
      failures++;
      $display("FAIL b2b_cnt got=%0d exp=3", o_cnt);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] es [3] = '{8'd2, 8'd4, 8'd6};
    int           k        = 0;
    int           got      = 0;
    int           unstable = 0;
    logic         acc_now;
    sel       = 0;
    op        = OP_ADD;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (k < 3);
      a        = W'(k + 1);
      b        = W'(k + 1);
      @(negedge clk);
      acc_now = in_valid && o_in_ready;
      if (o_valid && (o_s !== 8'd2 || o_flag !== 1'b1)) unstable++;
      @(posedge clk);
      #1;
      if (acc_now) k++;
    end
    checks++;
    if (k !== 2) begin
      failures++;
      $display("FAIL stall_accepted got=%0d exp=2", k);
    end
    checks++;
    if (o_in_ready !== 1'b0 || o_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_hs got=in_ready%b/out_valid%b exp=0/1",
               o_in_ready, o_valid);
    end
    checks++;
    if (unstable !== 0 || o_s !== 8'd2) begin
      failures++;
      $display("FAIL stall_hold got=%0d changes s=%h exp=0 changes s=02",
               unstable, o_s);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      in_valid = (k < 3);
      a        = W'(k + 1);
      b        = W'(k + 1);
      @(negedge clk);
      acc_now = in_valid && o_in_ready;
      if (o_valid) begin
        if (got < 3) begin
          checks++;
          if (o_s !== es[got]) begin
            failures++;
            $display("FAIL stall_order%0d got=%h exp=%h", got, o_s, es[got]);
          end
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (acc_now) k++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 3 || k !== 3) begin
      failures++;
      $display("FAIL stall_delivered got=%0d/%0d exp=3/3", got, k);
    end
  endtask

  task automatic test_reset_inflight();
    logic [W-1:0] rs;
    logic         rf;
    int           lat;
    int           stray = 0;
    sel = 0;
    xact(OP_LOAD, 8'd20, 8'd0, rs, rf, lat);
    xact(OP_ACC, 8'd30, 8'd0, rs, rf, lat);
    checks++;
    if (rs !== 8'd50 || rf !== 1'b1) begin
      failures++;
      $display("FAIL rst_acc50 got=%h/%b exp=32/1", rs, rf);
    end
    out_ready = 1'b0;
    op        = OP_ADD;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a        = W'(i + 1);
      b        = W'(i + 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_cnt !== 16'd3) begin
      failures++;
      $display("FAIL rst_pre got=valid%b cnt%0d exp=1/3", o_valid, o_cnt);
    end
    #2;
    rst0 = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_flag !== 1'b1 || o_cnt !== 16'd0 ||
        o_s !== 8'd0) begin
      failures++;
      $display("FAIL rst_async got=v%b f%b c%0d s%h exp=v0 f1 c0 s00",
               o_valid, o_flag, o_cnt, o_s);
    end
    @(posedge clk);
    #1;
    rst0      = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (o_valid) stray++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL rst_discard got=%0d stray beats exp=0", stray);
    end
    xact(OP_ACC, 8'd7, 8'd0, rs, rf, lat);
    checks++;
    if (rs !== 8'd7 || rf !== 1'b1) begin
      failures++;
      $display("FAIL rst_acc_cleared got=%h/%b exp=07/1", rs, rf);
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_add_sat();
    test_sub();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
